// File: rtl/wired_lsu_unit.sv
// In-order load/store responder: one request at a time from the LSU issue queue,
// alignment/LL-SC/barrier handling, single-beat data-memory access, in-order response.
package wired_lsu_pkg;
  typedef struct packed {
    logic [31:0] vaddr;
    logic        store;
    logic [1:0]  msize;
    logic        sext;
    logic        cacop;
    logic        dbar;
    logic        llsc;
    logic [31:0] wdata;
  } iq_lsu_req_t;

  typedef struct packed {
    logic        excp;
    logic [31:0] vaddr;
    logic        uncached;
    logic [31:0] rdata;
  } iq_lsu_resp_t;
endpackage

// state | meaning
// IDLE  | ready for a new request
// MREQ  | memory request presented, waiting for mem_req_ready_i
// MWAIT | memory request taken, waiting for mem_resp_valid_i
// RESP  | response presented, waiting for lsu_resp_ready_i
// DRAIN | flushed with an access in flight; swallow its memory response
module wired_lsu_unit
  import wired_lsu_pkg::*;
#(
  parameter logic [31:0] UC_BASE = 32'hA000_0000,
  parameter logic [31:0] UC_MASK = 32'hE000_0000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush_i,
  input  logic         lsu_req_valid_i,
  output logic         lsu_req_ready_o,
  input  iq_lsu_req_t  lsu_req_i,
  output logic         lsu_resp_valid_o,
  input  logic         lsu_resp_ready_i,
  output iq_lsu_resp_t lsu_resp_o,
  output logic         mem_req_valid_o,
  input  logic         mem_req_ready_i,
  output logic [31:0]  mem_addr_o,
  output logic         mem_we_o,
  output logic [3:0]   mem_wstrb_o,
  output logic [31:0]  mem_wdata_o,
  output logic         mem_uncached_o,
  input  logic         mem_resp_valid_i,
  input  logic [31:0]  mem_rdata_i
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_MREQ  = 3'd1,
    S_MWAIT = 3'd2,
    S_RESP  = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  state_t      r_state;
  iq_lsu_req_t r_req;
  logic        r_req_ready;
  logic        r_resp_valid;
  logic        r_mem_valid;
  logic        r_excp;
  logic [31:0] r_rdata;
  logic        r_llbit;
  logic [29:0] r_lladdr;

  logic        w_misal;
  logic        w_sc;
  logic        w_sc_hit;
  logic        w_uncached;
  logic [31:0] w_shifted;
  logic [31:0] w_load_data;
  logic [3:0]  w_strb_base;
  logic        w_unused;

  assign w_misal  = ((lsu_req_i.msize == 2'd1) && lsu_req_i.vaddr[0]) ||
                    ((lsu_req_i.msize == 2'd2) && (lsu_req_i.vaddr[1:0] != 2'b00));
  assign w_sc     = lsu_req_i.llsc && lsu_req_i.store;
  assign w_sc_hit = r_llbit && (r_lladdr == lsu_req_i.vaddr[31:2]);
  assign w_uncached = ((r_req.vaddr & UC_MASK) == UC_BASE);
  // Barrier/cacop flags only steer classification at accept time.
  assign w_unused = &{1'b0, r_req.cacop, r_req.dbar};

  assign w_shifted = mem_rdata_i >> {r_req.vaddr[1:0], 3'b000};

  always_comb begin
    w_load_data = w_shifted;
    case (r_req.msize)
      2'd0: w_load_data = {{24{r_req.sext & w_shifted[7]}}, w_shifted[7:0]};
      2'd1: w_load_data = {{16{r_req.sext & w_shifted[15]}}, w_shifted[15:0]};
      default: w_load_data = w_shifted;
    endcase
  end

  always_comb begin
    case (r_req.msize)
      2'd0:    w_strb_base = 4'b0001;
      2'd1:    w_strb_base = 4'b0011;
      default: w_strb_base = 4'b1111;
    endcase
  end

  assign mem_addr_o     = {r_req.vaddr[31:2], 2'b00};
  assign mem_we_o       = r_req.store;
  assign mem_wstrb_o    = r_req.store ? (w_strb_base << r_req.vaddr[1:0]) : 4'b0000;
  assign mem_wdata_o    = r_req.wdata << {r_req.vaddr[1:0], 3'b000};
  assign mem_uncached_o = w_uncached;
  assign mem_req_valid_o = r_mem_valid;

  assign lsu_req_ready_o  = r_req_ready;
  assign lsu_resp_valid_o = r_resp_valid;
  assign lsu_resp_o.excp     = r_excp;
  assign lsu_resp_o.vaddr    = r_req.vaddr;
  assign lsu_resp_o.uncached = w_uncached;
  assign lsu_resp_o.rdata    = r_rdata;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_req        <= '0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_mem_valid  <= 1'b0;
      r_excp       <= 1'b0;
      r_rdata      <= '0;
      r_llbit      <= 1'b0;
      r_lladdr     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!flush_i && lsu_req_valid_i) begin
            r_req       <= lsu_req_i;
            r_req_ready <= 1'b0;
            r_excp      <= 1'b0;
            r_rdata     <= '0;
            if (w_misal) begin
              r_excp       <= 1'b1;
              r_state      <= S_RESP;
              r_resp_valid <= 1'b1;
            end else if (lsu_req_i.dbar || lsu_req_i.cacop) begin
              r_state      <= S_RESP;
              r_resp_valid <= 1'b1;
            end else if (w_sc) begin
              r_llbit <= 1'b0;
              if (w_sc_hit) begin
                r_rdata     <= 32'd1;
                r_state     <= S_MREQ;
                r_mem_valid <= 1'b1;
              end else begin
                r_state      <= S_RESP;
                r_resp_valid <= 1'b1;
              end
            end else begin
              r_state     <= S_MREQ;
              r_mem_valid <= 1'b1;
            end
          end
        end
        S_MREQ: begin
          if (flush_i) begin
            r_mem_valid <= 1'b0;
            if (mem_req_ready_i) begin
              r_state <= S_DRAIN;
            end else begin
              r_state     <= S_IDLE;
              r_req_ready <= 1'b1;
            end
          end else if (mem_req_ready_i) begin
            r_mem_valid <= 1'b0;
            r_state     <= S_MWAIT;
          end
        end
        S_MWAIT: begin
          if (flush_i) begin
            // A response coincident with the flush is the one DRAIN would wait for.
            if (mem_resp_valid_i) begin
              r_state     <= S_IDLE;
              r_req_ready <= 1'b1;
            end else begin
              r_state <= S_DRAIN;
            end
          end else if (mem_resp_valid_i) begin
            r_state      <= S_RESP;
            r_resp_valid <= 1'b1;
            if (!r_req.store) begin
              r_rdata <= w_load_data;
            end
            if (r_req.llsc && !r_req.store) begin
              r_llbit  <= 1'b1;
              r_lladdr <= r_req.vaddr[31:2];
            end else if (r_req.store && !r_req.llsc && (r_lladdr == r_req.vaddr[31:2])) begin
              r_llbit <= 1'b0;
            end
          end
        end
        S_RESP: begin
          if (flush_i || lsu_resp_ready_i) begin
            r_state      <= S_IDLE;
            r_resp_valid <= 1'b0;
            r_req_ready  <= 1'b1;
          end
        end
        S_DRAIN: begin
          if (mem_resp_valid_i) begin
            r_state     <= S_IDLE;
            r_req_ready <= 1'b1;
          end
        end
        default: begin
          r_state      <= S_IDLE;
          r_req_ready  <= 1'b1;
          r_resp_valid <= 1'b0;
          r_mem_valid  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wired_lsu_unit.sv
// Scoreboard bench for wired_lsu_unit: expected responses queued at issue, popped on response.
module tb_wired_lsu_unit;

  typedef struct packed {
    logic [31:0] vaddr;
    logic        store;
    logic [1:0]  msize;
    logic        sext;
    logic        cacop;
    logic        dbar;
    logic        llsc;
    logic [31:0] wdata;
  } req_t;

  typedef struct packed {
    logic        excp;
    logic [31:0] vaddr;
    logic        uncached;
    logic [31:0] rdata;
  } resp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush_i = 1'b0;
  logic        lsu_req_valid_i = 1'b0;
  logic        lsu_req_ready_o;
  req_t        lsu_req_i = '0;
  logic        lsu_resp_valid_o;
  logic        lsu_resp_ready_i = 1'b0;
  resp_t       lsu_resp_o;
  logic        mem_req_valid_o;
  logic        mem_req_ready_i = 1'b0;
  logic [31:0] mem_addr_o;
  logic        mem_we_o;
  logic [3:0]  mem_wstrb_o;
  logic [31:0] mem_wdata_o;
  logic        mem_uncached_o;
  logic        mem_resp_valid_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;

  int n_chk = 0;
  int n_fail = 0;
  resp_t exp_q[$];

  always #5 clk = ~clk;

  wired_lsu_unit dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .flush_i          (flush_i),
    .lsu_req_valid_i  (lsu_req_valid_i),
    .lsu_req_ready_o  (lsu_req_ready_o),
    .lsu_req_i        (lsu_req_i),
    .lsu_resp_valid_o (lsu_resp_valid_o),
    .lsu_resp_ready_i (lsu_resp_ready_i),
    .lsu_resp_o       (lsu_resp_o),
    .mem_req_valid_o  (mem_req_valid_o),
    .mem_req_ready_i  (mem_req_ready_i),
    .mem_addr_o       (mem_addr_o),
    .mem_we_o         (mem_we_o),
    .mem_wstrb_o      (mem_wstrb_o),
    .mem_wdata_o      (mem_wdata_o),
    .mem_uncached_o   (mem_uncached_o),
    .mem_resp_valid_i (mem_resp_valid_i),
    .mem_rdata_i      (mem_rdata_i)
  );

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic req_t mk_req(input logic [31:0] va, input logic st, input logic [1:0] sz,
                                  input logic sx, input logic ll, input logic [31:0] wd);
    req_t r;
    r = '0;
    r.vaddr = va; r.store = st; r.msize = sz; r.sext = sx; r.llsc = ll; r.wdata = wd;
    return r;
  endfunction

  function automatic resp_t mk_resp(input logic ex, input logic [31:0] va, input logic uc,
                                    input logic [31:0] rd);
    resp_t r;
    r.excp = ex; r.vaddr = va; r.uncached = uc; r.rdata = rd;
    return r;
  endfunction

  // Issue one request, serve memory with ready at once and response one cycle later.
  task automatic run_txn(input string id, input req_t rq, input resp_t er, input logic has_mem,
                         input logic [31:0] mrd, input logic [3:0] e_strb,
                         input logic [31:0] e_wdata, input int e_lat);
    logic  saw_mem;
    logic  pend;
    logic  done;
    resp_t got;
    resp_t ex;
    int    k;
    saw_mem = 1'b0; pend = 1'b0; done = 1'b0; k = 0;
    exp_q.push_back(er);
    @(negedge clk);
    chk_val({id, ".req_ready"}, {31'd0, lsu_req_ready_o}, 32'd1);
    lsu_req_valid_i = 1'b1;
    lsu_req_i = rq;
    @(posedge clk);
    while (!done && k < 30) begin
      @(negedge clk);
      k++;
      lsu_req_valid_i = 1'b0;
      mem_req_ready_i = 1'b0;
      mem_resp_valid_i = 1'b0;
      mem_rdata_i = 32'h0;
      if (pend) begin
        mem_resp_valid_i = 1'b1;
        mem_rdata_i = mrd;
        pend = 1'b0;
      end
      if (mem_req_valid_o && !saw_mem) begin
        saw_mem = 1'b1;
        chk_val({id, ".mem_addr"}, mem_addr_o, {rq.vaddr[31:2], 2'b00});
        chk_val({id, ".mem_we"}, {31'd0, mem_we_o}, {31'd0, rq.store});
        chk_val({id, ".mem_wstrb"}, {28'd0, mem_wstrb_o}, {28'd0, e_strb});
        chk_val({id, ".mem_uc"}, {31'd0, mem_uncached_o}, {31'd0, er.uncached});
        if (rq.store) chk_val({id, ".mem_wdata"}, mem_wdata_o, e_wdata);
        mem_req_ready_i = 1'b1;
        pend = 1'b1;
      end
      if (lsu_resp_valid_o) begin
        chk_val({id, ".latency"}, k, e_lat);
        got = lsu_resp_o;
        if (exp_q.size() == 0) begin
          chk_val({id, ".unexpected_resp"}, 32'd1, 32'd0);
        end else begin
          ex = exp_q.pop_front();
          chk_val({id, ".excp"}, {31'd0, got.excp}, {31'd0, ex.excp});
          chk_val({id, ".vaddr"}, got.vaddr, ex.vaddr);
          chk_val({id, ".uncached"}, {31'd0, got.uncached}, {31'd0, ex.uncached});
          chk_val({id, ".rdata"}, got.rdata, ex.rdata);
        end
        lsu_resp_ready_i = 1'b1;
        @(posedge clk);
        #1 lsu_resp_ready_i = 1'b0;
        done = 1'b1;
      end
    end
    chk_val({id, ".done"}, {31'd0, done}, 32'd1);
    chk_val({id, ".mem_used"}, {31'd0, saw_mem}, {31'd0, has_mem});
  endtask

  req_t rq;

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_val("rst.req_ready", {31'd0, lsu_req_ready_o}, 32'd1);
    chk_val("rst.resp_valid", {31'd0, lsu_resp_valid_o}, 32'd0);
    chk_val("rst.mem_valid", {31'd0, mem_req_valid_o}, 32'd0);
    rst_n = 1'b1;
    chk_val("post_rst.req_ready", {31'd0, lsu_req_ready_o}, 32'd1);

    run_txn("ldw", mk_req(32'h0000_1004, 0, 2'd2, 0, 0, 0),
            mk_resp(0, 32'h0000_1004, 0, 32'hDEAD_BEEF), 1, 32'hDEAD_BEEF, 4'h0, 0, 3);
    run_txn("ldb_s_uc", mk_req(32'hA000_0003, 0, 2'd0, 1, 0, 0),
            mk_resp(0, 32'hA000_0003, 1, 32'hFFFF_FF80), 1, 32'h80FF_FF7F, 4'h0, 0, 3);
    run_txn("sth", mk_req(32'h0000_2002, 1, 2'd1, 0, 0, 32'h0000_1234),
            mk_resp(0, 32'h0000_2002, 0, 0), 1, 32'hFFFF_FFFF, 4'b1100, 32'h1234_0000, 3);
    run_txn("ldw_misal", mk_req(32'h0000_3001, 0, 2'd2, 0, 0, 0),
            mk_resp(1, 32'h0000_3001, 0, 0), 0, 0, 4'h0, 0, 1);

    run_txn("ll", mk_req(32'h0000_4000, 0, 2'd2, 0, 1, 0),
            mk_resp(0, 32'h0000_4000, 0, 32'h1122_3344), 1, 32'h1122_3344, 4'h0, 0, 3);
    run_txn("sc_ok", mk_req(32'h0000_4000, 1, 2'd2, 0, 1, 32'hCAFE_F00D),
            mk_resp(0, 32'h0000_4000, 0, 32'd1), 1, 0, 4'hF, 32'hCAFE_F00D, 3);
    run_txn("sc_fail", mk_req(32'h0000_4000, 1, 2'd2, 0, 1, 32'hCAFE_F00D),
            mk_resp(0, 32'h0000_4000, 0, 32'd0), 0, 0, 4'h0, 0, 1);

    // Flush in MWAIT after a delayed memory handshake: response dropped, DRAIN until mem resp.
    @(negedge clk);
    chk_val("fl.req_ready", {31'd0, lsu_req_ready_o}, 32'd1);
    lsu_req_valid_i = 1'b1;
    lsu_req_i = mk_req(32'h0000_5000, 0, 2'd2, 0, 0, 0);
    @(posedge clk);
    @(negedge clk);
    lsu_req_valid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk_val("fl.mem_hold_valid", {31'd0, mem_req_valid_o}, 32'd1);
      chk_val("fl.mem_hold_addr", mem_addr_o, 32'h0000_5000);
      @(negedge clk);
    end
    chk_val("fl.mem_valid", {31'd0, mem_req_valid_o}, 32'd1);
    mem_req_ready_i = 1'b1;
    @(negedge clk);
    mem_req_ready_i = 1'b0;
    chk_val("fl.mwait_mem_valid", {31'd0, mem_req_valid_o}, 32'd0);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk_val("fl.drain_ready", {31'd0, lsu_req_ready_o}, 32'd0);
      chk_val("fl.drain_resp", {31'd0, lsu_resp_valid_o}, 32'd0);
      @(negedge clk);
    end
    mem_resp_valid_i = 1'b1;
    mem_rdata_i = 32'h9999_9999;
    @(negedge clk);
    mem_resp_valid_i = 1'b0;
    mem_rdata_i = 32'h0;
    chk_val("fl.after_ready", {31'd0, lsu_req_ready_o}, 32'd1);
    chk_val("fl.after_resp", {31'd0, lsu_resp_valid_o}, 32'd0);
    run_txn("fl_next", mk_req(32'h0000_5000, 0, 2'd2, 0, 0, 0),
            mk_resp(0, 32'h0000_5000, 0, 32'h55AA_55AA), 1, 32'h55AA_55AA, 4'h0, 0, 3);

    run_txn("ldhu", mk_req(32'h0000_8002, 0, 2'd1, 0, 0, 0),
            mk_resp(0, 32'h0000_8002, 0, 32'h0000_BEEF), 1, 32'hBEEF_1234, 4'h0, 0, 3);
    run_txn("ldhs", mk_req(32'h0000_8002, 0, 2'd1, 1, 0, 0),
            mk_resp(0, 32'h0000_8002, 0, 32'hFFFF_BEEF), 1, 32'hBEEF_1234, 4'h0, 0, 3);

    run_txn("ll2", mk_req(32'h0000_6000, 0, 2'd2, 0, 1, 0),
            mk_resp(0, 32'h0000_6000, 0, 32'h0BAD_F00D), 1, 32'h0BAD_F00D, 4'h0, 0, 3);
    run_txn("stb_clr", mk_req(32'h0000_6001, 1, 2'd0, 0, 0, 32'h0000_00AB),
            mk_resp(0, 32'h0000_6001, 0, 0), 1, 0, 4'b0010, 32'h0000_AB00, 3);
    run_txn("sc_cleared", mk_req(32'h0000_6000, 1, 2'd2, 0, 1, 32'h1),
            mk_resp(0, 32'h0000_6000, 0, 0), 0, 0, 4'h0, 0, 1);

    rq = mk_req(32'hA000_0100, 0, 2'd2, 0, 0, 0);
    rq.dbar = 1'b1;
    run_txn("dbar", rq, mk_resp(0, 32'hA000_0100, 1, 0), 0, 0, 4'h0, 0, 1);
    run_txn("ldh_misal", mk_req(32'h0000_7001, 0, 2'd1, 1, 0, 0),
            mk_resp(1, 32'h0000_7001, 0, 0), 0, 0, 4'h0, 0, 1);
    run_txn("stb_hi", mk_req(32'h0000_7003, 1, 2'd0, 0, 0, 32'h0000_005A),
            mk_resp(0, 32'h0000_7003, 0, 0), 1, 0, 4'b1000, 32'h5A00_0000, 3);

    chk_val("scoreboard_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
